// File: rtl/fofir_pkg.sv
// Shared constants for the FoFIR tap sequencer.
//   MAX_TAPS : number of inputs on the 11:1 tap mux
//   SEL_W    : width of the tap mux select
//   OCNT_W   : width of the output-sample counter
//   IDLE/RUN/HOLD/DONE : sequencer state encoding
package fofir_pkg;

    localparam int MAX_TAPS = 11;
    localparam int SEL_W    = 4;
    localparam int OCNT_W   = 16;

    typedef logic [1:0] seq_state_t;

    localparam seq_state_t IDLE = 2'd0;
    localparam seq_state_t RUN  = 2'd1;
    localparam seq_state_t HOLD = 2'd2;
    localparam seq_state_t DONE = 2'd3;

endpackage

// File: rtl/fofir_tap_sequencer.sv
// Tap sequencer for the FoFIR 11:1 tap mux and its accumulator.
// Steps tap_sel through 0..taps-1 (one tap per in_valid beat), presents
// result_valid until out_ready, repeats for num_outputs samples, pulses done.
//
// Ports:
//   clk, rst_n              clock, async active-low reset
//   start, abort            job request (IDLE only) / synchronous abort
//   cfg_num_taps/outputs    job config, latched on an accepted start
//   in_valid, out_ready     tap beat available / consumer takes the result
//   busy, tap_sel           job in progress / registered mux select
//   acc_en, acc_first       accumulate strobe / load-instead-of-add qualifier
//   result_valid/last       finished sample / final sample of the job
//   done, cfg_err           one-cycle pulses: job complete / start rejected
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start; validates config
// RUN   | stepping taps, one per in_valid beat
// HOLD  | sample finished, waiting for out_ready
// DONE  | one-cycle done pulse, then IDLE
module fofir_tap_sequencer
    import fofir_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [SEL_W-1:0]  cfg_num_taps,
    input  logic [OCNT_W-1:0] cfg_num_outputs,
    input  logic              in_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic [SEL_W-1:0]  tap_sel,
    output logic              acc_en,
    output logic              acc_first,
    output logic              result_valid,
    output logic              result_last,
    output logic              done,
    output logic              cfg_err
);

    localparam logic [SEL_W-1:0] MAX_TAPS_SEL = SEL_W'(MAX_TAPS);

    seq_state_t        state, state_nxt;
    logic [SEL_W-1:0]  tap_cnt, tap_cnt_nxt;
    logic [OCNT_W-1:0] out_cnt, out_cnt_nxt;
    logic [SEL_W-1:0]  taps_q, taps_nxt;
    logic [OCNT_W-1:0] outs_q, outs_nxt;
    logic              cfg_err_nxt;
    logic              cfg_ok;
    logic              last_tap;
    logic              last_out;

    assign cfg_ok   = (cfg_num_taps != '0) && (cfg_num_taps <= MAX_TAPS_SEL)
                      && (cfg_num_outputs != '0);
    // latched values are never 0 inside a job, so the minus-one cannot wrap
    assign last_tap = (tap_cnt == taps_q - SEL_W'(1));
    assign last_out = (out_cnt == outs_q - OCNT_W'(1));

    // tap_cnt is forced to 0 on every exit from RUN, so it doubles as the
    // registered mux select and is 0 whenever not in RUN
    assign tap_sel = tap_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            tap_cnt <= '0;
            out_cnt <= '0;
            taps_q  <= '0;
            outs_q  <= '0;
            cfg_err <= 1'b0;
        end else begin
            state   <= state_nxt;
            tap_cnt <= tap_cnt_nxt;
            out_cnt <= out_cnt_nxt;
            taps_q  <= taps_nxt;
            outs_q  <= outs_nxt;
            cfg_err <= cfg_err_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        tap_cnt_nxt  = tap_cnt;
        out_cnt_nxt  = out_cnt;
        taps_nxt     = taps_q;
        outs_nxt     = outs_q;
        cfg_err_nxt  = 1'b0;
        busy         = 1'b0;
        acc_en       = 1'b0;
        acc_first    = 1'b0;
        result_valid = 1'b0;
        result_last  = 1'b0;
        done         = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    if (cfg_ok) begin
                        state_nxt   = RUN;
                        taps_nxt    = cfg_num_taps;
                        outs_nxt    = cfg_num_outputs;
                        tap_cnt_nxt = '0;
                        out_cnt_nxt = '0;
                    end else begin
                        cfg_err_nxt = 1'b1;
                    end
                end
            end
            RUN: begin
                busy      = 1'b1;
                acc_en    = in_valid;
                acc_first = in_valid && (tap_cnt == '0);
                if (in_valid) begin
                    if (last_tap) begin
                        tap_cnt_nxt = '0;
                        state_nxt   = HOLD;
                    end else begin
                        tap_cnt_nxt = tap_cnt + SEL_W'(1);
                    end
                end
            end
            HOLD: begin
                busy         = 1'b1;
                result_valid = 1'b1;
                result_last  = last_out;
                if (out_ready) begin
                    if (last_out) begin
                        state_nxt = DONE;
                    end else begin
                        out_cnt_nxt = out_cnt + OCNT_W'(1);
                        state_nxt   = RUN;
                    end
                end
            end
            DONE: begin
                busy        = 1'b1;
                done        = 1'b1;
                out_cnt_nxt = '0;
                state_nxt   = IDLE;
            end
            default: state_nxt = IDLE;
        endcase

        // abort beats any simultaneous beat, handshake or start
        if (abort && (state != IDLE)) begin
            state_nxt   = IDLE;
            tap_cnt_nxt = '0;
            out_cnt_nxt = '0;
        end
    end

endmodule

// File: tb/tb_fofir_tap_sequencer.sv
// Self-checking bench for fofir_tap_sequencer: directed scenarios plus a
// randomized run, all compared cycle by cycle against a job-level model.
module tb_fofir_tap_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, abort, in_valid, out_ready;
    logic [3:0]  cfg_num_taps;
    logic [15:0] cfg_num_outputs;
    logic        busy, acc_en, acc_first, result_valid, result_last, done, cfg_err;
    logic [3:0]  tap_sel;

    fofir_tap_sequencer dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .cfg_num_taps(cfg_num_taps), .cfg_num_outputs(cfg_num_outputs),
        .in_valid(in_valid), .out_ready(out_ready), .busy(busy),
        .tap_sel(tap_sel), .acc_en(acc_en), .acc_first(acc_first),
        .result_valid(result_valid), .result_last(result_last),
        .done(done), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    // Job-level model: a job is "active" from the accepted start until the
    // cycle after done; within it we are either collecting taps, holding a
    // finished sample, or finishing.
    bit m_active, m_hold, m_fin, m_cerr;
    int m_taps, m_outs, m_beats, m_samples;

    int cnt_acc, cnt_first, cnt_rv, cnt_last, cnt_done, cnt_cerr, max_sel;
    bit saw_done;

    task automatic m_reset();
        m_active = 0; m_hold = 0; m_fin = 0; m_cerr = 0;
        m_taps = 0; m_outs = 0; m_beats = 0; m_samples = 0;
    endtask

    task automatic clear_counts();
        cnt_acc = 0; cnt_first = 0; cnt_rv = 0; cnt_last = 0;
        cnt_done = 0; cnt_cerr = 0; max_sel = 0;
    endtask

    task automatic m_step();
        m_cerr = 0;
        if (!m_active) begin
            if (start) begin
                if (cfg_num_taps >= 1 && cfg_num_taps <= 11 && cfg_num_outputs >= 1) begin
                    m_active = 1; m_hold = 0; m_fin = 0;
                    m_taps = cfg_num_taps; m_outs = cfg_num_outputs;
                    m_beats = 0; m_samples = 0;
                end else begin
                    m_cerr = 1;
                end
            end
        end else if (abort) begin
            m_reset();
        end else if (m_fin) begin
            m_reset();
        end else if (m_hold) begin
            if (out_ready) begin
                m_hold = 0;
                if (m_samples == m_outs - 1) m_fin = 1;
                else m_samples++;
            end
        end else if (in_valid) begin
            m_beats++;
            if (m_beats == m_taps) begin
                m_beats = 0;
                m_hold = 1;
            end
        end
    endtask

    task automatic compare_all();
        bit collecting;
        collecting = m_active && !m_hold && !m_fin;
        chk("busy", busy, m_active);
        chk("tap_sel", tap_sel, collecting ? m_beats : 0);
        chk("acc_en", acc_en, collecting && in_valid);
        chk("acc_first", acc_first, collecting && in_valid && m_beats == 0);
        chk("result_valid", result_valid, m_hold);
        chk("result_last", result_last, m_hold && (m_samples == m_outs - 1));
        chk("done", done, m_fin);
        chk("cfg_err", cfg_err, m_cerr);
        cnt_acc   += acc_en;
        cnt_first += acc_en && acc_first;
        cnt_rv    += result_valid;
        cnt_last  += result_last;
        cnt_done  += done;
        cnt_cerr  += cfg_err;
        if (int'(tap_sel) > max_sel) max_sel = tap_sel;
        saw_done = done;
    endtask

    // inputs are set just after a rising edge; outputs are checked on the
    // falling edge; the model advances on the rising edge
    task automatic tick();
        @(negedge clk);
        compare_all();
        @(posedge clk);
        if (!rst_n) m_reset();
        else m_step();
        #1;
    endtask

    task automatic idle_inputs();
        start = 0; abort = 0; in_valid = 0; out_ready = 0;
        cfg_num_taps = 0; cfg_num_outputs = 0;
    endtask

    task automatic launch(input int taps, input int outs);
        cfg_num_taps = 4'(taps);
        cfg_num_outputs = 16'(outs);
        start = 1;
        tick();
        start = 0;
        cfg_num_taps = 4'($urandom);
        cfg_num_outputs = 16'($urandom);
    endtask

    task automatic finish_job(input string tag);
        int n = 0;
        while (m_active && n < 400) begin
            tick();
            n++;
        end
        chk(tag, n < 400, 1);
    endtask

    initial begin
        int n;
        idle_inputs();
        rst_n = 0;
        m_reset();
        clear_counts();
        #1;
        chk("reset_busy", busy, 0);
        chk("reset_tap_sel", tap_sel, 0);
        chk("reset_rv", result_valid, 0);
        chk("reset_cfg_err", cfg_err, 0);
        tick();
        tick();
        rst_n = 1;
        tick();

        // basic job: 10 cycles from start to done
        clear_counts();
        in_valid = 1; out_ready = 1;
        cfg_num_taps = 3; cfg_num_outputs = 2; start = 1;
        n = 0; saw_done = 0;
        while (!saw_done && n < 50) begin
            tick();
            start = 0;
            n++;
        end
        chk("basic_cycles", n, 10);
        chk("basic_rv", cnt_rv, 2);
        chk("basic_last", cnt_last, 1);
        chk("basic_acc", cnt_acc, 6);
        tick();
        chk("basic_done_cnt", cnt_done, 1);

        // max taps with bubbles
        clear_counts();
        launch(11, 1);
        n = 0;
        while (m_active && n < 200) begin
            in_valid = (n % 2 == 0);
            tick();
            n++;
        end
        chk("maxtap_bound", n < 200, 1);
        chk("maxtap_acc", cnt_acc, 11);
        chk("maxtap_first", cnt_first, 1);
        chk("maxtap_maxsel", max_sel, 10);
        chk("maxtap_done", cnt_done, 1);

        // backpressure in the first HOLD
        clear_counts();
        in_valid = 1; out_ready = 0;
        launch(2, 3);
        n = 0;
        while (m_active && n < 200) begin
            if (cnt_rv >= 5) out_ready = 1;
            tick();
            n++;
        end
        chk("bp_bound", n < 200, 1);
        chk("bp_rv_cycles", cnt_rv, 8);
        chk("bp_done", cnt_done, 1);

        // config errors and a start while running
        clear_counts();
        in_valid = 0; out_ready = 1;
        launch(0, 3);  tick();
        launch(12, 3); tick();
        launch(5, 0);  tick();
        chk("cfgerr_pulses", cnt_cerr, 3);
        chk("cfgerr_busy", busy, 0);
        clear_counts();
        launch(4, 1);
        tick();
        launch(0, 0);
        launch(3, 2);
        in_valid = 1;
        finish_job("busy_start_bound");
        chk("busy_start_cerr", cnt_cerr, 0);
        chk("busy_start_acc", cnt_acc, 4);

        // abort at tap 5, then a fresh job
        clear_counts();
        in_valid = 1;
        launch(8, 2);
        n = 0;
        while (m_beats != 5 && n < 50) begin tick(); n++; end
        chk("abort_reach", m_beats, 5);
        chk("abort_sel_before", tap_sel, 5);
        abort = 1; out_ready = 1;
        tick();
        abort = 0;
        tick();
        chk("abort_idle", busy, 0);
        chk("abort_no_done", cnt_done, 0);
        launch(2, 1);
        finish_job("abort_fresh_bound");
        chk("abort_fresh_done", cnt_done, 1);

        // single tap per sample
        clear_counts();
        in_valid = 1; out_ready = 1;
        launch(1, 4);
        finish_job("one_tap_bound");
        chk("one_tap_acc", cnt_acc, 4);
        chk("one_tap_first", cnt_first, 4);
        chk("one_tap_rv", cnt_rv, 4);
        chk("one_tap_done", cnt_done, 1);

        // asynchronous reset while holding a result
        in_valid = 1; out_ready = 0;
        launch(3, 2);
        n = 0;
        while (!m_hold && n < 50) begin tick(); n++; end
        @(negedge clk);
        chk("hold_rv", result_valid, 1);
        #2;
        rst_n = 0;
        #1;
        chk("async_rv", result_valid, 0);
        chk("async_busy", busy, 0);
        chk("async_tap_sel", tap_sel, 0);
        m_reset();
        @(posedge clk); #1;
        idle_inputs();
        tick();
        rst_n = 1;
        tick();

        // randomized traffic
        clear_counts();
        for (int i = 0; i < 4000; i++) begin
            start     = ($urandom_range(0, 9) == 0);
            abort     = ($urandom_range(0, 49) == 0);
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 6);
            if ($urandom_range(0, 3) == 0) cfg_num_taps = 4'($urandom);
            else cfg_num_taps = 4'($urandom_range(1, 11));
            cfg_num_outputs = 16'($urandom_range(0, 4));
            tick();
        end
        chk("rand_maxsel", max_sel <= 10, 1);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/fofir_tap_sequencer.md
Name: fofir_tap_sequencer

Overview:
- Control FSM that drives the 4-bit select of the FoFIR 11:1 tap mux (data_width 16) and the enables of the downstream accumulator.
- For each output sample it steps tap_sel through 0..cfg_num_taps-1, one tap per accepted input beat.
- After the last tap it presents result_valid and holds it until out_ready.
- It repeats this for cfg_num_outputs samples, then pulses done.

Parameters:
- MAX_TAPS, 11, number of mux inputs; legal cfg_num_taps range is 1..MAX_TAPS.
- SEL_W, 4, width of tap_sel; must satisfy 2^SEL_W >= MAX_TAPS.
- OCNT_W, 16, width of the output-sample counter and cfg_num_outputs.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to begin a job; sampled only in IDLE.
- abort  in  1  synchronous abort; returns the block to IDLE.
- cfg_num_taps  in  SEL_W  taps per output sample; latched on accepted start.
- cfg_num_outputs  in  OCNT_W  output samples per job; latched on accepted start.
- in_valid  in  1  tap operand available at the mux inputs this cycle.
- out_ready  in  1  consumer accepts the result.
- busy  out  1  high in RUN, HOLD and DONE.
- tap_sel  out  SEL_W  mux select, registered.
- acc_en  out  1  accumulate the mux output this cycle.
- acc_first  out  1  qualifies acc_en: load instead of add (tap 0).
- result_valid  out  1  accumulator holds a finished sample.
- result_last  out  1  result_valid for the final sample of the job.
- done  out  1  one-cycle pulse at job completion.
- cfg_err  out  1  one-cycle pulse when a start is rejected.

Behaviour:
- Reset: rst_n low forces, asynchronously, state=IDLE, tap_cnt=0, out_cnt=0, latched config=0, and every output = 0. This applies mid-job too; no done is pulsed.
- Clock/reset: one clock (clk); reset is asynchronous and active-low (rst_n).
- States: IDLE, RUN, HOLD, DONE, encoded as localparams.
- IDLE:
  - start with cfg_num_taps in 1..MAX_TAPS and cfg_num_outputs >= 1 → latch config, clear both counters, go to RUN next cycle.
  - Any other start → cfg_err=1 for the next cycle only; stay in IDLE.
- RUN:
  - tap_sel = tap_cnt (registered).
  - acc_en = in_valid (combinational from the state).
  - acc_first = acc_en && tap_cnt==0.
  - in_valid=0 → hold; counter and tap_sel do not move.
  - in_valid=1 and tap_cnt < taps-1 → tap_cnt++.
  - in_valid=1 and tap_cnt == taps-1 → tap_cnt=0, go to HOLD.
- HOLD:
  - result_valid=1 and acc_en=0.
  - result_last = (out_cnt == num_outputs-1).
  - out_ready=0 → stay in HOLD; result_valid stays high.
  - On handshake, if not last → out_cnt++ and return to RUN (tap_sel=0).
  - On handshake, if last → go to DONE.
- DONE: done=1 for one cycle, then IDLE with busy=0.
- Latency:
  - First acc_en is possible 1 cycle after start.
  - result_valid rises 1 cycle after the last-tap beat; this matches the 1-cycle accumulator register.
  - Minimum cycles per sample = taps + 1.
- tap_sel never exceeds taps-1 (≤ 10), so the mux default/X arm is never selected. tap_sel is 0 whenever not in RUN.
- taps = 1: every in_valid beat is both acc_first and the last tap, and goes straight to HOLD.
- abort: in any non-IDLE state, next cycle is IDLE with counters cleared and all outputs 0; no done. abort takes precedence over every simultaneous in_valid, out_ready or start.
- start while busy is ignored and produces no cfg_err.
- Config inputs are don't-care except in the cycle a start is accepted.
- Counter widths: tap_cnt is SEL_W bits and out_cnt is OCNT_W bits. Comparisons are against the latched values minus 1, evaluated at full width with no wrap.

Decomposition:
- Shared package fofir_pkg holds:
  - MAX_TAPS=11 and SEL_W=4.
  - The state encoding localparams: IDLE=2'd0, RUN=2'd1, HOLD=2'd2, DONE=2'd3.
- Single module; no sub-module is warranted. Optionally instantiate the existing mux in the bench only.

Test Plan:
- Basic job: start, taps=3, outputs=2, in_valid=1, out_ready=1 → tap_sel 0,1,2; HOLD; 0,1,2; HOLD; result_valid pulses twice; result_last on the 2nd; done exactly 1 cycle after the 2nd handshake; 10 cycles total from start to done.
- Max taps with bubbles: taps=11, outputs=1, in_valid toggling 1,0,1,... → tap_sel advances only on in_valid=1; reaches 10, never 11–15; acc_en count=11, acc_first count=1.
- Backpressure: taps=2, outputs=3, out_ready low for 5 cycles in the first HOLD → result_valid stays high 5+1 cycles; tap_sel=0 and acc_en=0 throughout; all 3 samples then complete.
- Config errors: start with taps=0, taps=12 and outputs=0 → cfg_err 1-cycle pulse each; busy stays 0. Start while in RUN → ignored.
- Abort and reset: abort in RUN at tap_cnt=5 → IDLE next cycle, no done, a fresh start works. rst_n low in HOLD → all outputs 0 immediately (asynchronously, before the next clk edge).
- taps=1, outputs=4, in_valid=1, out_ready=1 → acc_en alternates 1,0 with acc_first=1 on every beat; 4 results; done.
